aquarius_sdram_arbiter: RTL and testbench

Sequences and shares the single SDRAM controller port of the Aquarius core between three requesters: ROM/tape download writes, Z80 memory cycles and the tape player's sample fetch. Replaces the combinational address/strobe mux in the top level with a registered, one-access-at-a-time scheduler. It owns fixed priority, address mapping, the CPU wait handshake, the read-data latches and a watchdog. It sits between the top-level glue and the `sdram` controller.

---
 rtl/aquarius_sdram_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_aquarius_sdram_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aquarius_sdram_arbiter.sv
// Registered scheduler for the Aquarius SDRAM controller port: download, CPU and tape
// requesters share one access at a time under fixed priority, with a WAIT watchdog.
module aquarius_sdram_arbiter #(
  parameter int TIMEOUT = 63
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [1:0]  dl_index,
  input  logic [15:0] dl_addr,
  input  logic [7:0]  dl_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_wait_n,
  output logic        cpu_hold,
  input  logic        tape_req,
  input  logic [15:0] tape_addr,
  input  logic        tape_window,
  output logic [7:0]  tape_data,
  output logic        tape_ack,
  output logic [22:0] sdram_addr,
  output logic [15:0] sdram_din,
  output logic        sdram_rd,
  output logic        sdram_we,
  input  logic [15:0] sdram_dout,
  input  logic        sdram_ready,
  output logic        dl_overrun,
  output logic        timeout_err
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  // S_IDLE pick winner | S_ISSUE strobe | S_WAIT await ready or watchdog | S_DONE ack and release
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_DL, OWN_CPU, OWN_TAPE} owner_t;

  state_t      state_q;
  owner_t      owner_q;
  logic        wr_q;
  logic        buf_full_q, buf_fresh_q;
  logic [1:0]  buf_idx_q;
  logic [15:0] buf_addr_q;
  logic [7:0]  buf_data_q;
  logic        served_q, cpu_drop_q;
  logic [WDW-1:0] wd_q;
  logic [22:0] sdram_addr_q;
  logic [15:0] sdram_din_q;
  logic        sdram_rd_q, sdram_we_q;
  logic [7:0]  cpu_rdata_q, tape_data_q;
  logic        tape_ack_q, dl_overrun_q, timeout_err_q;

  owner_t      grant_d;
  logic        gnt_we_d;
  logic [22:0] gnt_addr_d;
  logic [15:0] gnt_din_d;

  logic        cpu_pend, tape_first, dl_take, dl_done, cpu_keep;
  logic [7:0]  rd_byte;
  logic        unused_dout;

  function automatic logic [22:0] map_dl(input logic [1:0] idx, input logic [15:0] a);
    case (idx)
      2'b00:   map_dl = {10'd0, a[12:0]};
      2'b01:   map_dl = {7'd0, 2'b11, a[13:0]};
      default: map_dl = {6'd0, 1'b1, a};
    endcase
  endfunction

  assign cpu_pend    = cpu_req & ~served_q & ~dl_active;
  assign tape_first  = tape_req & (tape_window | ~cpu_pend);
  assign dl_take     = dl_wr & (dl_index != 2'b11);
  assign dl_done     = (state_q == S_DONE) && (owner_q == OWN_DL);
  assign cpu_keep    = cpu_req & ~cpu_drop_q;
  assign rd_byte     = sdram_ready ? sdram_dout[7:0] : 8'hFF;
  assign unused_dout = ^sdram_dout[15:8];

  always_comb begin
    grant_d    = OWN_NONE;
    gnt_we_d   = 1'b0;
    gnt_addr_d = '0;
    gnt_din_d  = '0;
    if (buf_full_q) begin
      grant_d    = OWN_DL;
      gnt_we_d   = 1'b1;
      gnt_addr_d = map_dl(buf_idx_q, buf_addr_q);
      gnt_din_d  = {8'h00, buf_data_q};
    end else if (tape_first) begin
      grant_d    = OWN_TAPE;
      gnt_addr_d = {6'd0, 1'b1, tape_addr};
    end else if (cpu_pend) begin
      grant_d    = OWN_CPU;
      gnt_we_d   = cpu_we;
      gnt_addr_d = {7'd0, cpu_addr};
      gnt_din_d  = {8'h00, cpu_wdata};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      owner_q       <= OWN_NONE;
      wr_q          <= 1'b0;
      buf_full_q    <= 1'b0;
      buf_fresh_q   <= 1'b0;
      buf_idx_q     <= '0;
      buf_addr_q    <= '0;
      buf_data_q    <= '0;
      served_q      <= 1'b0;
      cpu_drop_q    <= 1'b0;
      wd_q          <= '0;
      sdram_addr_q  <= '0;
      sdram_din_q   <= '0;
      sdram_rd_q    <= 1'b0;
      sdram_we_q    <= 1'b0;
      cpu_rdata_q   <= 8'hFF;
      tape_data_q   <= '0;
      tape_ack_q    <= 1'b0;
      dl_overrun_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      sdram_rd_q <= 1'b0;
      sdram_we_q <= 1'b0;
      tape_ack_q <= 1'b0;
      if (!cpu_req) served_q <= 1'b0;

      // fresh = a byte not yet handed to SDRAM, so an overwrite during its own write survives DONE
      if (dl_take) begin
        buf_full_q  <= 1'b1;
        buf_fresh_q <= 1'b1;
        buf_idx_q   <= dl_index;
        buf_addr_q  <= dl_addr;
        buf_data_q  <= dl_data;
        if (buf_full_q && !dl_done) dl_overrun_q <= 1'b1;
      end else if (dl_done) begin
        buf_full_q <= buf_fresh_q;
      end

      case (state_q)
        S_IDLE: begin
          if (grant_d != OWN_NONE) begin
            state_q      <= S_ISSUE;
            owner_q      <= grant_d;
            wr_q         <= gnt_we_d;
            sdram_addr_q <= gnt_addr_d;
            sdram_din_q  <= gnt_din_d;
            sdram_we_q   <= gnt_we_d;
            sdram_rd_q   <= ~gnt_we_d;
            cpu_drop_q   <= 1'b0;
            if (grant_d == OWN_DL && !dl_take) buf_fresh_q <= 1'b0;
          end
        end
        S_ISSUE: begin
          state_q <= S_WAIT;
          wd_q    <= WDW'(TIMEOUT - 1);
          if (owner_q == OWN_CPU && !cpu_req) cpu_drop_q <= 1'b1;
        end
        S_WAIT: begin
          if (owner_q == OWN_CPU && !cpu_req) cpu_drop_q <= 1'b1;
          if (sdram_ready || wd_q == '0) begin
            state_q <= S_DONE;
            if (!sdram_ready) timeout_err_q <= 1'b1;
            if (!wr_q && owner_q == OWN_CPU && cpu_keep) cpu_rdata_q <= rd_byte;
            if (!wr_q && owner_q == OWN_TAPE) tape_data_q <= rd_byte;
            if (owner_q == OWN_TAPE) tape_ack_q <= 1'b1;
          end else begin
            wd_q <= wd_q - 1'b1;
          end
        end
        S_DONE: begin
          if (owner_q == OWN_CPU && cpu_keep) served_q <= 1'b1;
          state_q <= S_IDLE;
          owner_q <= OWN_NONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cpu_wait_n  = ~(cpu_req & ~served_q);
  assign cpu_hold    = dl_active;
  assign cpu_rdata   = cpu_rdata_q;
  assign tape_data   = tape_data_q;
  assign tape_ack    = tape_ack_q;
  assign sdram_addr  = sdram_addr_q;
  assign sdram_din   = sdram_din_q;
  assign sdram_rd    = sdram_rd_q;
  assign sdram_we    = sdram_we_q;
  assign dl_overrun  = dl_overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_aquarius_sdram_arbiter.sv
// Directed and randomized checks of aquarius_sdram_arbiter against an address/latency model
// and a behavioural SDRAM responder that logs every command.
module tb_aquarius_sdram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        dl_active, dl_wr;
  logic [1:0]  dl_index;
  logic [15:0] dl_addr;
  logic [7:0]  dl_data;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_wait_n, cpu_hold;
  logic        tape_req, tape_window;
  logic [15:0] tape_addr;
  logic [7:0]  tape_data;
  logic        tape_ack;
  logic [22:0] sdram_addr;
  logic [15:0] sdram_din;
  logic        sdram_rd, sdram_we;
  logic [15:0] sdram_dout;
  logic        sdram_ready = 1'b0;
  logic        dl_overrun, timeout_err;

  aquarius_sdram_arbiter #(.TIMEOUT(63)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .dl_active(dl_active), .dl_wr(dl_wr), .dl_index(dl_index), .dl_addr(dl_addr), .dl_data(dl_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_wait_n(cpu_wait_n), .cpu_hold(cpu_hold),
    .tape_req(tape_req), .tape_addr(tape_addr), .tape_window(tape_window),
    .tape_data(tape_data), .tape_ack(tape_ack),
    .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_rd(sdram_rd), .sdram_we(sdram_we),
    .sdram_dout(sdram_dout), .sdram_ready(sdram_ready),
    .dl_overrun(dl_overrun), .timeout_err(timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        we;
    logic [22:0] addr;
    logic [15:0] din;
  } cmd_t;
  cmd_t log_q[$];

  int lat_cfg = 1;
  bit hang = 1'b0;
  int cd = 0;

  // SDRAM model: ready arrives lat_cfg cycles after the command pulse, never when hung
  always @(negedge clk_sys) begin
    sdram_ready = 1'b0;
    if (!reset_n) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) sdram_ready = 1'b1;
      end
      if (sdram_rd || sdram_we) begin
        log_q.push_back('{sdram_we, sdram_addr, sdram_din});
        if (!hang) cd = lat_cfg;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(negedge clk_sys);
  endtask

  task automatic wait_cpu(output int k);
    k = 0;
    while (k < 200) begin
      step();
      k++;
      if (cpu_wait_n) break;
    end
  endtask

  function automatic logic [31:0] exp_dl_addr(input int idx, input logic [15:0] a);
    logic [31:0] w;
    w = {16'h0, a};
    if (idx == 0) return w % 32'd8192;
    if (idx == 1) return 32'hC000 + (w % 32'd16384);
    return 32'h10000 + w;
  endfunction

  int          kind, idx, k, acks;
  logic [15:0] a;
  logic [7:0]  d, eb;

  initial begin
    reset_n = 1'b0; dl_active = 1'b0; dl_wr = 1'b0; dl_index = 2'b00; dl_addr = '0; dl_data = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tape_req = 1'b0; tape_addr = '0; tape_window = 1'b0; sdram_dout = '0;
    repeat (3) step();
    chk("rst_rdata", 32'(cpu_rdata), 32'hFF);
    chk("rst_tdata", 32'(tape_data), 32'h0);
    chk("rst_addr", 32'(sdram_addr), 32'h0);
    chk("rst_din", 32'(sdram_din), 32'h0);
    chk("rst_strobes", 32'({sdram_rd, sdram_we, tape_ack}), 32'h0);
    chk("rst_flags", 32'({dl_overrun, timeout_err}), 32'h0);
    chk("rst_wait_n", 32'(cpu_wait_n), 32'h1);
    reset_n = 1'b1;
    step();

    // download to ext ROM
    log_q.delete(); lat_cfg = 1;
    dl_active = 1'b1; dl_index = 2'b01; dl_addr = 16'h0005; dl_data = 8'hA5; dl_wr = 1'b1;
    step();
    dl_wr = 1'b0;
    chk("dl_hold", 32'(cpu_hold), 32'h1);
    chk("dl_we_c0", 32'(sdram_we), 32'h0);
    step();
    chk("dl_we_c1", 32'(sdram_we), 32'h1);
    chk("dl_addr", 32'(sdram_addr), 32'h00C005);
    chk("dl_din", 32'(sdram_din), 32'h00A5);
    step();
    chk("dl_we_c2", 32'(sdram_we), 32'h0);
    repeat (8) step();
    chk("dl_once", 32'(log_q.size()), 32'd1);
    dl_active = 1'b0;

    // CPU read, latency 2, request held for 10 cycles
    log_q.delete(); lat_cfg = 2; sdram_dout = 16'h1234;
    cpu_addr = 16'h3800; cpu_we = 1'b0; cpu_req = 1'b1;
    #1 chk("rd_wait_c0", 32'(cpu_wait_n), 32'h0);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("rd_wait_low", 32'(cpu_wait_n), 32'h0);
      if (c == 1) chk("rd_strobe", 32'({sdram_rd, sdram_we}), 32'h2);
      if (c == 2) chk("rd_addr_held", 32'(sdram_addr), 32'h003800);
    end
    step();
    chk("rd_wait_c5", 32'(cpu_wait_n), 32'h1);
    chk("rd_data", 32'(cpu_rdata), 32'h34);
    repeat (4) step();
    chk("rd_wait_c9", 32'(cpu_wait_n), 32'h1);
    cpu_req = 1'b0;
    repeat (3) step();
    chk("rd_one_pulse", 32'(log_q.size()), 32'd1);

    // simultaneous CPU and tape, outside the refresh window
    log_q.delete(); lat_cfg = 1; sdram_dout = 16'h0042;
    cpu_addr = 16'h1111; tape_addr = 16'h2222; tape_window = 1'b0;
    cpu_req = 1'b1; tape_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tape_ack) tape_req = 1'b0;
    end
    cpu_req = 1'b0;
    repeat (2) step();
    chk("pri_w0_cnt", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("pri_w0_first", 32'(log_q[0].addr), 32'h001111);
      chk("pri_w0_second", 32'(log_q[1].addr), 32'h010000 + 32'h2222);
    end
    chk("pri_rdata", 32'(cpu_rdata), 32'h42);

    // same again inside the refresh window: tape preempts
    log_q.delete();
    cpu_addr = 16'h3333; tape_addr = 16'h4444; tape_window = 1'b1;
    cpu_req = 1'b1; tape_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tape_ack) tape_req = 1'b0;
    end
    cpu_req = 1'b0; tape_window = 1'b0;
    repeat (2) step();
    chk("pri_w1_cnt", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("pri_w1_first", 32'(log_q[0].addr), 32'h010000 + 32'h4444);
      chk("pri_w1_second", 32'(log_q[1].addr), 32'h003333);
    end
    chk("tape_data", 32'(tape_data), 32'h42);

    // two download bytes back to back while a CPU read sits in WAIT
    log_q.delete(); lat_cfg = 6;
    cpu_addr = 16'h5555; cpu_req = 1'b1;
    repeat (2) step();
    dl_index = 2'b00; dl_addr = 16'h0100; dl_data = 8'h11; dl_wr = 1'b1;
    step();
    dl_addr = 16'hF234; dl_data = 8'h22;
    step();
    dl_wr = 1'b0;
    repeat (8) step();
    cpu_req = 1'b0;
    repeat (10) step();
    chk("ovr_flag", 32'(dl_overrun), 32'h1);
    chk("ovr_cnt", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("ovr_we", 32'(log_q[1].we), 32'h1);
      chk("ovr_addr", 32'(log_q[1].addr), exp_dl_addr(0, 16'hF234));
      chk("ovr_din", 32'(log_q[1].din), 32'h0022);
    end

    // watchdog on a CPU read that never completes
    hang = 1'b1;
    cpu_addr = 16'h6666; cpu_req = 1'b1;
    chk("to_flag_pre", 32'(timeout_err), 32'h0);
    wait_cpu(k);
    chk("to_cycles", 32'(k), 32'd66);
    chk("to_rdata", 32'(cpu_rdata), 32'hFF);
    chk("to_flag", 32'(timeout_err), 32'h1);
    cpu_req = 1'b0;
    repeat (2) step();

    // reset during WAIT of a tape read
    tape_addr = 16'h0777; tape_req = 1'b1;
    repeat (3) step();
    reset_n = 1'b0;
    step();
    chk("mrst_addr", 32'(sdram_addr), 32'h0);
    chk("mrst_din", 32'(sdram_din), 32'h0);
    chk("mrst_strobes", 32'({sdram_rd, sdram_we, tape_ack}), 32'h0);
    chk("mrst_tdata", 32'(tape_data), 32'h0);
    chk("mrst_flags", 32'({dl_overrun, timeout_err}), 32'h0);
    chk("mrst_rdata", 32'(cpu_rdata), 32'hFF);
    reset_n = 1'b1; tape_req = 1'b0; hang = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tape_ack) acks++;
    end
    chk("mrst_no_ack", 32'(acks), 32'd0);

    // CPU held off while a download is active
    log_q.delete(); lat_cfg = 1;
    dl_active = 1'b1; cpu_addr = 16'h0ABC; cpu_we = 1'b0; cpu_req = 1'b1;
    repeat (6) step();
    chk("hold_no_cmd", 32'(log_q.size()), 32'd0);
    chk("hold_wait_n", 32'(cpu_wait_n), 32'h0);
    dl_active = 1'b0;
    wait_cpu(k);
    chk("hold_release", 32'(k), 32'd4);
    cpu_req = 1'b0;
    repeat (2) step();

    // randomized single-requester traffic
    for (int t = 0; t < 30; t++) begin
      kind = int'($urandom_range(0, 3));
      a = 16'($urandom);
      d = 8'($urandom);
      lat_cfg = int'($urandom_range(1, 4));
      sdram_dout = 16'($urandom);
      eb = sdram_dout[7:0];
      log_q.delete();
      case (kind)
        0: begin
          idx = int'($urandom_range(0, 3));
          dl_active = 1'b1; dl_index = 2'(idx); dl_addr = a; dl_data = d; dl_wr = 1'b1;
          step();
          dl_wr = 1'b0;
          repeat (6 + lat_cfg) step();
          dl_active = 1'b0;
          if (idx == 3) begin
            chk("rnd_dl_drop", 32'(log_q.size()), 32'd0);
          end else begin
            chk("rnd_dl_cnt", 32'(log_q.size()), 32'd1);
            if (log_q.size() == 1) begin
              chk("rnd_dl_we", 32'(log_q[0].we), 32'h1);
              chk("rnd_dl_addr", 32'(log_q[0].addr), exp_dl_addr(idx, a));
              chk("rnd_dl_din", 32'(log_q[0].din), {24'h0, d});
            end
          end
        end
        1, 2: begin
          cpu_we = (kind == 1); cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
          wait_cpu(k);
          chk("rnd_cpu_lat", 32'(k), 32'(3 + lat_cfg));
          if (kind == 2) chk("rnd_cpu_rdata", 32'(cpu_rdata), {24'h0, eb});
          cpu_req = 1'b0;
          repeat (2) step();
          chk("rnd_cpu_cnt", 32'(log_q.size()), 32'd1);
          if (log_q.size() == 1) begin
            chk("rnd_cpu_we", 32'(log_q[0].we), 32'(kind == 1));
            chk("rnd_cpu_addr", 32'(log_q[0].addr), {16'h0, a});
            if (kind == 1) chk("rnd_cpu_din", 32'(log_q[0].din), {24'h0, d});
          end
        end
        default: begin
          tape_addr = a; tape_req = 1'b1;
          k = 0;
          do begin
            step();
            k++;
          end while (!tape_ack && k < 200);
          chk("rnd_tape_lat", 32'(k), 32'(2 + lat_cfg));
          chk("rnd_tape_data", 32'(tape_data), {24'h0, eb});
          tape_req = 1'b0;
          repeat (2) step();
          chk("rnd_tape_cnt", 32'(log_q.size()), 32'd1);
          if (log_q.size() == 1)
            chk("rnd_tape_addr", 32'(log_q[0].addr), 32'h10000 + {16'h0, a});
        end
      endcase
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
